// File: rtl/sweep_counter.sv
// Sweep counter: counts 0..lim_q once or repeatedly while VS is high,
// with pause/hold, a terminal-count DONE pulse and a saturating sweep tally.
module sweep_counter #(
  parameter int WIDTH  = 12,
  parameter int WRAP_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VS,
  input  logic              PAUSE,
  input  logic              MODE,
  input  logic [WIDTH-1:0]  LIMIT,
  output logic              CNT_D,
  output logic [WIDTH-1:0]  COUNT,
  output logic              DONE,
  output logic [WRAP_W-1:0] WRAPS
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, FIN} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_lim;
  logic               r_mode;
  logic [WIDTH-1:0]   r_count;
  logic               r_cnt_d;
  logic               r_done;
  logic [WRAP_W-1:0]  r_wraps;

  logic               w_term;
  logic [WRAP_W-1:0]  w_wraps_inc;

  assign w_term      = (r_count == r_lim);
  assign w_wraps_inc = (r_wraps == {WRAP_W{1'b1}}) ? r_wraps : r_wraps + WRAP_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_lim   <= {WIDTH{1'b1}};
      r_mode  <= 1'b0;
      r_count <= '0;
      r_cnt_d <= 1'b0;
      r_done  <= 1'b0;
      r_wraps <= '0;
    end else if (!VS) begin
      // Dropping VS aborts from any state, ahead of pause or terminal count
      r_state <= IDLE;
      r_count <= '0;
      r_cnt_d <= 1'b0;
      r_done  <= 1'b0;
      r_wraps <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= RUN;
          r_lim   <= (LIMIT == '0) ? {WIDTH{1'b1}} : LIMIT;
          r_mode  <= MODE;
          r_count <= '0;
          r_cnt_d <= 1'b1;
          r_done  <= 1'b0;
          r_wraps <= '0;
        end
        RUN: begin
          r_done <= 1'b0;
          if (PAUSE) begin
            r_state <= HOLD;
            r_cnt_d <= 1'b0;
          end else if (w_term) begin
            r_done  <= 1'b1;
            r_wraps <= w_wraps_inc;
            if (r_mode) begin
              r_count <= '0;
              r_cnt_d <= 1'b1;
            end else begin
              r_state <= FIN;
              r_cnt_d <= 1'b0;
            end
          end else begin
            r_count <= r_count + WIDTH'(1);
            r_cnt_d <= 1'b1;
          end
        end
        HOLD: begin
          r_done <= 1'b0;
          if (!PAUSE) begin
            r_state <= RUN;
            r_cnt_d <= 1'b1;
          end
        end
        FIN: begin
          r_done <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
          r_cnt_d <= 1'b0;
          r_done  <= 1'b0;
          r_wraps <= '0;
        end
      endcase
    end
  end

  assign CNT_D = r_cnt_d;
  assign COUNT = r_count;
  assign DONE  = r_done;
  assign WRAPS = r_wraps;

endmodule

// File: tb/tb_sweep_counter.sv
// Directed bench for sweep_counter at WIDTH=4, WRAP_W=2; outputs are packed
// as {CNT_D, COUNT, DONE, WRAPS} and checked once per clock.
module tb_sweep_counter;

  logic       clk;
  logic       rst;
  logic       vs;
  logic       pause;
  logic       mode;
  logic [3:0] limit;
  logic       cnt_d;
  logic [3:0] count;
  logic       done;
  logic [1:0] wraps;

  int n_vec;
  int n_err;

  sweep_counter #(.WIDTH(4), .WRAP_W(2)) dut (
    .CLK   (clk),
    .RST   (rst),
    .VS    (vs),
    .PAUSE (pause),
    .MODE  (mode),
    .LIMIT (limit),
    .CNT_D (cnt_d),
    .COUNT (count),
    .DONE  (done),
    .WRAPS (wraps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic cd, input logic [3:0] c,
                                    input logic dn, input logic [1:0] w);
    return {cd, c, dn, w};
  endfunction

  task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got cnt_d/count/done/wraps=%b/%0d/%b/%0d required %b/%0d/%b/%0d",
               tag, obs[7], obs[6:3], obs[2], obs[1:0], exp[7], exp[6:3], exp[2], exp[1:0]);
    end else begin
      $display("ok   %s: cnt_d=%b count=%0d done=%b wraps=%0d",
               tag, obs[7], obs[6:3], obs[2], obs[1:0]);
    end
  endtask

  // Advance one clock, then compare the registered outputs 1 time unit later
  task automatic cyc(input string tag, input int cd, input int c, input int dn, input int w);
    @(posedge clk);
    #1;
    check_vec(tag, pk(cnt_d, count, done, wraps), pk(1'(cd), 4'(c), 1'(dn), 2'(w)));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; vs = 1'b1; pause = 1'b0; mode = 1'b0; limit = 4'd5;

    cyc("reset0", 0, 0, 0, 0);
    cyc("reset1", 0, 0, 0, 0);

    // One-shot LIMIT=5 straight out of reset; LIMIT moves to 9 mid-sweep
    rst = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      cyc("oneshot", 1, i, 0, 0);
      if (i == 2) limit = 4'd9;
    end
    cyc("oneshot_done", 0, 5, 1, 1);
    cyc("oneshot_fin", 0, 5, 0, 1);
    cyc("oneshot_fin", 0, 5, 0, 1);
    vs = 1'b0;
    cyc("idle_a", 0, 0, 0, 0);

    // Continuous LIMIT=2; MODE dropped mid-run must be ignored
    limit = 4'd2; mode = 1'b1; vs = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      int c;
      int w;
      c = (k - 1) % 3;
      w = (k - 1) / 3;
      if (w > 3) w = 3;
      cyc("contin", 1, c, (k > 1 && c == 0) ? 1 : 0, w);
      if (k == 5) mode = 1'b0;
    end

    // VS 1->0->1 restarts with a fresh latch: LIMIT=7 one-shot with pauses
    vs = 1'b0; limit = 4'd7;
    cyc("toggle_idle", 0, 0, 0, 0);
    vs = 1'b1;
    for (int i = 0; i <= 3; i++) cyc("pause_run", 1, i, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) cyc("pause_hold", 0, 3, 0, 0);
    pause = 1'b0;
    cyc("pause_resume", 1, 3, 0, 0);
    for (int i = 4; i <= 7; i++) cyc("pause_run", 1, i, 0, 0);
    pause = 1'b1;
    cyc("pause_at_term", 0, 7, 0, 0);
    pause = 1'b0;
    cyc("pause_term_resume", 1, 7, 0, 0);
    cyc("pause_done", 0, 7, 1, 1);
    cyc("pause_fin", 0, 7, 0, 1);
    vs = 1'b0;
    cyc("idle_b", 0, 0, 0, 0);

    // Full range: LIMIT=0 means terminal count 15, no overflow
    limit = 4'd0; vs = 1'b1;
    for (int i = 0; i <= 15; i++) cyc("full", 1, i, 0, 0);
    cyc("full_done", 0, 15, 1, 1);
    cyc("full_fin", 0, 15, 0, 1);
    vs = 1'b0;
    cyc("idle_c", 0, 0, 0, 0);

    // Abort at COUNT=4
    limit = 4'd9; vs = 1'b1;
    for (int i = 0; i <= 4; i++) cyc("abort_run", 1, i, 0, 0);
    vs = 1'b0;
    cyc("abort_idle", 0, 0, 0, 0);
    cyc("abort_idle2", 0, 0, 0, 0);

    // Reset on the terminal-count edge suppresses DONE
    limit = 4'd3; vs = 1'b1;
    for (int i = 0; i <= 3; i++) cyc("rstterm_run", 1, i, 0, 0);
    rst = 1'b1;
    cyc("rstterm_rst", 0, 0, 0, 0);
    rst = 1'b0;
    cyc("rstterm_rel", 1, 0, 0, 0);
    cyc("rstterm_rel", 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
